// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, load-data extraction and alignment,
// register-file write control and a retired-instruction counter.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallW,
    input  logic        flushW,
    input  logic        validM,
    input  logic        regwriteM,
    input  logic        memtoregM,
    input  logic [2:0]  loadtypeM,
    input  logic [1:0]  addrlowM,
    input  logic [4:0]  writeregM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] readdataM,
    input  logic [31:0] pcM,
    output logic        regwriteW,
    output logic [4:0]  writeregW,
    output logic [31:0] resultW,
    output logic        validW,
    output logic [31:0] pcW,
    output logic [31:0] retire_cnt
);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    logic        valid_p1;
    logic        regwrite_p1;
    logic        memtoreg_p1;
    logic [2:0]  loadtype_p1;
    logic [1:0]  addrlow_p1;
    logic [4:0]  writereg_p1;
    logic [31:0] aluout_p1;
    logic [31:0] readdata_p1;
    logic [31:0] pc_p1;
    logic        leaving;

    function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
        logic signed [31:0] r;
        r = b;
        return r;
    endfunction

    function automatic logic signed [31:0] sext16(input logic signed [15:0] h);
        logic signed [31:0] r;
        r = h;
        return r;
    endfunction

    // Little-endian lane select followed by sign or zero extension; codes
    // outside the defined set fall back to a full-word load.
    function automatic logic [31:0] extract_load(input logic [2:0]  lt,
                                                 input logic [1:0]  al,
                                                 input logic [31:0] w);
        logic [7:0]  byte_sel;
        logic [15:0] half_sel;
        logic [31:0] r;
        case (al)
            2'd0:    byte_sel = w[7:0];
            2'd1:    byte_sel = w[15:8];
            2'd2:    byte_sel = w[23:16];
            default: byte_sel = w[31:24];
        endcase
        half_sel = al[1] ? w[31:16] : w[15:0];
        case (lt)
            LT_LB:   r = sext8(byte_sel);
            LT_LBU:  r = {24'd0, byte_sel};
            LT_LH:   r = sext16(half_sel);
            LT_LHU:  r = {16'd0, half_sel};
            default: r = w;
        endcase
        return r;
    endfunction

    // ---- MEM -> WB register (p1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_p1    <= 1'b0;
            regwrite_p1 <= 1'b0;
            memtoreg_p1 <= 1'b0;
            loadtype_p1 <= 3'd0;
            addrlow_p1  <= 2'd0;
            writereg_p1 <= 5'd0;
            aluout_p1   <= 32'd0;
            readdata_p1 <= 32'd0;
            pc_p1       <= 32'd0;
        end else if (flushW) begin
            valid_p1    <= 1'b0;
            regwrite_p1 <= 1'b0;
        end else if (!stallW) begin
            valid_p1    <= validM;
            regwrite_p1 <= regwriteM;
            memtoreg_p1 <= memtoregM;
            loadtype_p1 <= loadtypeM;
            addrlow_p1  <= addrlowM;
            writereg_p1 <= writeregM;
            aluout_p1   <= aluoutM;
            readdata_p1 <= readdataM;
            pc_p1       <= pcM;
        end
    end

    // An entry retires when it leaves the stage, either advanced or flushed out.
    assign leaving = valid_p1 && (!stallW || flushW);

    always_ff @(posedge clk) begin
        if (rst)
            retire_cnt <= 32'd0;
        else if (leaving)
            retire_cnt <= retire_cnt + 32'd1;
    end

    // ---- WB outputs, from p1 state only ----
    assign validW    = valid_p1;
    assign writeregW = writereg_p1;
    assign pcW       = pc_p1;
    assign regwriteW = valid_p1 && regwrite_p1 && (writereg_p1 != 5'd0);
    assign resultW   = memtoreg_p1 ? extract_load(loadtype_p1, addrlow_p1, readdata_p1)
                                   : aluout_p1;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: a behavioural model predicts the post-edge
// outputs for each driven cycle, which are queued and compared after the edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stallW, flushW, validM, regwriteM, memtoregM;
    logic [2:0]  loadtypeM;
    logic [1:0]  addrlowM;
    logic [4:0]  writeregM;
    logic [31:0] aluoutM, readdataM, pcM;
    logic        regwriteW, validW;
    logic [4:0]  writeregW;
    logic [31:0] resultW, pcW, retire_cnt;

    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] res;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        exact;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // model state
    logic        m_v, m_rw, m_mtr;
    logic [2:0]  m_lt;
    logic [1:0]  m_al;
    logic [4:0]  m_wr;
    logic [31:0] m_alu, m_rd, m_pc, m_cnt;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .stallW(stallW), .flushW(flushW),
        .validM(validM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .loadtypeM(loadtypeM), .addrlowM(addrlowM), .writeregM(writeregM),
        .aluoutM(aluoutM), .readdataM(readdataM), .pcM(pcM),
        .regwriteW(regwriteW), .writeregW(writeregW), .resultW(resultW),
        .validW(validW), .pcW(pcW), .retire_cnt(retire_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [1:0] al,
                                               input logic [31:0] w);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> (8 * al);
        b  = sh[7:0];
        h  = al[1] ? w[31:16] : w[15:0];
        case (lt)
            3'd1:    return {{24{b[7]}}, b};
            3'd2:    return {24'h0, b};
            3'd3:    return {{16{h[15]}}, h};
            3'd4:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic cyc(input logic r, input logic st, input logic fl, input logic v,
                       input logic rw, input logic mtr, input logic [2:0] lt,
                       input logic [1:0] al, input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [31:0] pc_i);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst = r; stallW = st; flushW = fl; validM = v; regwriteM = rw; memtoregM = mtr;
        loadtypeM = lt; addrlowM = al; writeregM = wr; aluoutM = alu; readdataM = rd; pcM = pc_i;
        e.exact = 1'b0;
        if (r) begin
            {m_v, m_rw, m_mtr, m_lt, m_al, m_wr} = '0;
            m_alu = 0; m_rd = 0; m_pc = 0; m_cnt = 0;
            e.exact = 1'b1;
        end else begin
            if (m_v && (!st || fl)) m_cnt = m_cnt + 1;
            if (fl) begin
                m_v = 0; m_rw = 0;
            end else if (!st) begin
                m_v = v; m_rw = rw; m_mtr = mtr; m_lt = lt; m_al = al;
                m_wr = wr; m_alu = alu; m_rd = rd; m_pc = pc_i;
            end
        end
        e.v   = m_v;
        e.rw  = m_v & m_rw & (m_wr != 0);
        e.wr  = m_wr;
        e.res = m_mtr ? model_load(m_lt, m_al, m_rd) : m_alu;
        e.pc  = m_pc;
        e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check_val("validW", {31'd0, validW}, {31'd0, got.v});
        check_val("regwriteW", {31'd0, regwriteW}, {31'd0, got.rw});
        check_val("retire_cnt", retire_cnt, got.cnt);
        if (got.v || got.exact) begin
            check_val("writeregW", {27'd0, writeregW}, {27'd0, got.wr});
            check_val("resultW", resultW, got.res);
            check_val("pcW", pcW, got.pc);
        end
    endtask

    task automatic bubble();
        cyc(0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    logic [31:0] load_word;
    logic [31:0] c0;

    initial begin
        rst = 1; stallW = 0; flushW = 0; validM = 0; regwriteM = 0; memtoregM = 0;
        loadtypeM = 0; addrlowM = 0; writeregM = 0; aluoutM = 0; readdataM = 0; pcM = 0;
        m_v = 0; m_rw = 0; m_mtr = 0; m_lt = 0; m_al = 0; m_wr = 0;
        m_alu = 0; m_rd = 0; m_pc = 0; m_cnt = 0;

        // reset state
        cyc(1, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd3, 32'hDEAD_BEEF, 32'h1, 32'h44);
        cyc(1, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd3, 32'hDEAD_BEEF, 32'h1, 32'h44);
        check_val("rst_resultW", resultW, 32'h0);
        check_val("rst_cnt", retire_cnt, 32'h0);

        // ALU writeback
        cyc(0, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd5, 32'h1234_5678, 32'h0, 32'h100);
        check_val("alu_we", {31'd0, regwriteW}, 32'd1);
        check_val("alu_wa", {27'd0, writeregW}, 32'd5);
        check_val("alu_wd", resultW, 32'h1234_5678);
        check_val("alu_cnt_before", retire_cnt, 32'd0);
        bubble();
        check_val("alu_cnt_after", retire_cnt, 32'd1);

        // load extraction
        load_word = 32'h80F0_7F81;
        cyc(0, 0, 0, 1, 1, 1, 3'd1, 2'd0, 5'd7, 32'h0, load_word, 32'h200);
        check_val("lb0", resultW, 32'hFFFF_FF81);
        cyc(0, 0, 0, 1, 1, 1, 3'd2, 2'd0, 5'd7, 32'h0, load_word, 32'h204);
        check_val("lbu0", resultW, 32'h0000_0081);
        cyc(0, 0, 0, 1, 1, 1, 3'd1, 2'd1, 5'd7, 32'h0, load_word, 32'h208);
        check_val("lb1", resultW, 32'h0000_007F);
        cyc(0, 0, 0, 1, 1, 1, 3'd3, 2'd2, 5'd7, 32'h0, load_word, 32'h20C);
        check_val("lh2", resultW, 32'hFFFF_80F0);
        cyc(0, 0, 0, 1, 1, 1, 3'd4, 2'd2, 5'd7, 32'h0, load_word, 32'h210);
        check_val("lhu2", resultW, 32'h0000_80F0);
        cyc(0, 0, 0, 1, 1, 1, 3'd0, 2'd3, 5'd7, 32'h0, load_word, 32'h214);
        check_val("lw", resultW, 32'h80F0_7F81);
        cyc(0, 0, 0, 1, 1, 1, 3'd3, 2'd3, 5'd7, 32'h0, load_word, 32'h218);
        check_val("lh3", resultW, 32'hFFFF_80F0);
        cyc(0, 0, 0, 1, 1, 1, 3'd1, 2'd3, 5'd7, 32'h0, load_word, 32'h21C);
        check_val("lb3", resultW, 32'hFFFF_FF80);
        cyc(0, 0, 0, 1, 1, 1, 3'd7, 2'd2, 5'd7, 32'h0, load_word, 32'h220);
        check_val("lt7", resultW, 32'h80F0_7F81);

        // $0 suppression
        cyc(0, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd0, 32'h5555_0000, 32'h0, 32'h300);
        check_val("r0_we", {31'd0, regwriteW}, 32'd0);
        check_val("r0_valid", {31'd0, validW}, 32'd1);

        // stall then flush
        cyc(0, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd9, 32'hAAAA_5555, 32'h0, 32'h400);
        c0 = retire_cnt;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 1, 1, 0, 3'd0, 2'd0, 5'd10, 32'h1111_1111 * (i + 1), 32'h0, 32'h500);
            check_val("stall_hold", resultW, 32'hAAAA_5555);
            check_val("stall_cnt", retire_cnt, c0);
        end
        cyc(0, 1, 1, 1, 1, 0, 3'd0, 2'd0, 5'd10, 32'h2222_2222, 32'h0, 32'h504);
        check_val("flush_valid", {31'd0, validW}, 32'd0);
        check_val("flush_we", {31'd0, regwriteW}, 32'd0);
        check_val("flush_cnt", retire_cnt, c0 + 32'd1);

        // reset during stall
        cyc(0, 0, 0, 1, 1, 1, 3'd1, 2'd0, 5'd11, 32'h0, 32'h0000_00F0, 32'h600);
        cyc(0, 1, 0, 1, 1, 0, 3'd0, 2'd0, 5'd12, 32'h0, 32'h0, 32'h604);
        cyc(1, 1, 0, 1, 1, 0, 3'd0, 2'd0, 5'd12, 32'h0, 32'h0, 32'h604);
        check_val("rst_stall_cnt", retire_cnt, 32'd0);
        check_val("rst_stall_pc", pcW, 32'd0);

        // randomised traffic
        for (int i = 0; i < 80; i++) begin
            cyc(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                3'($urandom_range(0, 7)), 2'($urandom), 5'($urandom), $urandom, $urandom,
                $urandom);
        end

        // counter wrap
        cyc(0, 0, 0, 1, 1, 0, 3'd0, 2'd0, 5'd13, 32'hCAFE_F00D, 32'h0, 32'h700);
        force dut.retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt;
        m_cnt = 32'hFFFF_FFFF;
        bubble();
        check_val("wrap", retire_cnt, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
